// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper board logic: grid sizing, LFSR taps,
// mine-generator FSM states and the LFSR step function.
package minesweeper_pkg;

    localparam int unsigned DEF_ROWS   = 8;
    localparam int unsigned DEF_COLS   = 8;
    localparam int unsigned GRID_CELLS = DEF_ROWS * DEF_COLS;
    localparam int unsigned CELL_IDX_W = $clog2(GRID_CELLS);

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        PLACE,
        DONE
    } gen_state_e;

    // One right-shifting Galois step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with synchronous load and a guard that
// replaces any all-zero next state with the seed.
module lfsr16
    import minesweeper_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    logic [15:0] q_next;

    always_comb begin
        q_next = load ? load_val : lfsr_step(q);
        if (q_next == '0) begin
            q_next = SEED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/mine_field_gen.sv
// Random mine layout generator: places exactly NUM_MINES mines on the board
// using an LFSR, never on the protected cell, and publishes the layout on ready.
module mine_field_gen
    import minesweeper_pkg::*;
#(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned NUM_MINES = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [15:0]                       seed_in,
    input  logic                              safe_en,
    input  logic [$clog2(ROWS*COLS)-1:0]      safe_pos,
    output logic [0:ROWS*COLS-1]              init_mines,
    output logic [7:0]                        mine_count,
    output logic                              busy,
    output logic                              ready
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned IDX_W = $clog2(CELLS);
    localparam logic [7:0]  LAST_COUNT = 8'(NUM_MINES - 1);

    if (CELLS < 2 || CELLS > 65536 || (CELLS & (CELLS - 1)) != 0) begin : g_bad_grid
        $error("mine_field_gen: ROWS*COLS must be a power of two in 2..65536");
    end
    if (NUM_MINES < 1 || NUM_MINES > CELLS - 1 || NUM_MINES > 255) begin : g_bad_mines
        $error("mine_field_gen: NUM_MINES must be in 1..ROWS*COLS-1 and fit 8 bits");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("mine_field_gen: LFSR_SEED must be nonzero");
    end

    gen_state_e          state, state_next;
    logic [15:0]         lfsr_q;
    logic [IDX_W-1:0]    idx;
    logic [0:CELLS-1]    field;
    logic                accept;
    logic                place_ok;

    assign idx = lfsr_q[IDX_W-1:0];

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (lfsr_q ^ seed_in),
        .q        (lfsr_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In DONE, busy is still high on the first cycle, so start is only honoured
    // once the layout has actually been published.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        place_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = PLACE;
            end
            PLACE: begin
                place_ok = !field[idx] && !(safe_en && (idx == safe_pos));
                if (place_ok && (mine_count == LAST_COUNT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start && !busy) begin
                    accept     = 1'b1;
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            field      <= '0;
            init_mines <= '0;
            mine_count <= '0;
            busy       <= 1'b0;
            ready      <= 1'b0;
        end else begin
            if (accept) begin
                busy  <= 1'b1;
                ready <= 1'b0;
            end
            case (state)
                CLEAR: begin
                    field      <= '0;
                    mine_count <= '0;
                end
                PLACE: begin
                    if (place_ok) begin
                        field[idx] <= 1'b1;
                        mine_count <= mine_count + 8'd1;
                    end
                end
                DONE: begin
                    if (!accept) begin
                        init_mines <= field;
                        ready      <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mine_field_gen.sv
// Scoreboard bench for mine_field_gen: a reference LFSR/placement model predicts
// each layout and its latency when start is driven; results are checked on ready.
module tb_mine_field_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic [0:63] field;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2;
    logic [15:0] seed_in, seed2;
    logic        safe_en;
    logic [5:0]  safe_pos;
    logic [0:63] init_mines, init2;
    logic [7:0]  mine_count, count2;
    logic        busy, ready, busy2, ready2;

    logic        m_accept;
    logic [15:0] m_lfsr;
    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mine_field_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed_in    (seed_in),
        .safe_en    (safe_en),
        .safe_pos   (safe_pos),
        .init_mines (init_mines),
        .mine_count (mine_count),
        .busy       (busy),
        .ready      (ready)
    );

    mine_field_gen #(
        .NUM_MINES(63)
    ) dut63 (
        .clk        (clk),
        .reset      (reset),
        .start      (start2),
        .seed_in    (seed2),
        .safe_en    (1'b1),
        .safe_pos   (6'd0),
        .init_mines (init2),
        .mine_count (count2),
        .busy       (busy2),
        .ready      (ready2)
    );

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] n;
        n = {1'b0, v[15:1]};
        if (v[0]) n = n ^ 16'hB400;
        if (n == 16'h0000) n = SEED;
        return n;
    endfunction

    // Reference LFSR for the main DUT, tracking reset, seed mix and free-run stepping.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr <= SEED;
        end else if (m_accept) begin
            m_lfsr <= ((m_lfsr ^ seed_in) == 16'h0000) ? SEED : (m_lfsr ^ seed_in);
        end else begin
            m_lfsr <= ref_step(m_lfsr);
        end
    end

    // l0 is the LFSR value held during the CLEAR cycle; p counts PLACE cycles.
    function automatic void model_gen(input logic [15:0] l0, input logic se,
                                      input logic [5:0] sp, input int nm,
                                      output logic [0:63] f, output int p);
        logic [15:0] l;
        logic [5:0]  ix;
        int          cnt;
        l   = ref_step(l0);
        f   = '0;
        cnt = 0;
        p   = 0;
        while (cnt < nm && p < 20000) begin
            ix = l[5:0];
            p++;
            if (!f[ix] && !(se && ix == sp)) begin
                f[ix] = 1'b1;
                cnt++;
            end
            l = ref_step(l);
        end
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse start at a negedge and push the predicted layout and latency.
    task automatic start_gen(input logic [15:0] s, input logic hold);
        logic [0:63] f;
        int          p;
        exp_t        e;
        seed_in  = s;
        start    = 1'b1;
        m_accept = 1'b1;
        @(negedge clk);
        m_accept = 1'b0;
        if (!hold) start = 1'b0;
        model_gen(m_lfsr, safe_en, safe_pos, 10, f, p);
        e.field = f;
        e.lat   = p + 2;
        sb.push_back(e);
    endtask

    task automatic wait_result(input string tag, input logic chk_hold, input logic [0:63] old);
        int   k;
        exp_t e;
        k = 0;
        while (!ready && k < 3000) begin
            if (chk_hold) check_val({tag, "_hold"}, init_mines, old);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check_val({tag, "_ready"}, ready, 1);
        e = sb.pop_front();
        check_val({tag, "_lat"}, k, e.lat);
        check_val({tag, "_field"}, init_mines, e.field);
        check_val({tag, "_count"}, mine_count, 10);
        check_val({tag, "_pop"}, $countones(init_mines), 10);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [0:63] old;
        logic [63:0] exp63;
        int          k;

        reset    = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        seed_in  = '0;
        seed2    = 16'h0F0F;
        safe_en  = 1'b0;
        safe_pos = '0;
        m_accept = 1'b0;
        old      = '0;
        repeat (3) @(negedge clk);
        check_val("rst_mines", init_mines, 0);
        check_val("rst_count", mine_count, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", ready, 0);
        check_val("rst63_ready", ready2, 0);

        // First active edge sees lfsr == SEED, so seed_in == SEED mixes to zero.
        reset = 1'b1;
        start_gen(16'hACE1, 1'b0);
        wait_result("seedzero", 1'b0, old);
        check_val("lfsr_nonzero", (dut.lfsr_q == 16'h0000), 0);

        start_gen(16'h1234, 1'b0);
        wait_result("default", 1'b0, old);

        // Reset in the middle of PLACE, with start held to show reset wins.
        start_gen(16'h5555, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        #1;
        check_val("midrst_mines", init_mines, 0);
        check_val("midrst_count", mine_count, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_ready", ready, 0);
        void'(sb.pop_front());
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rstwin_busy", busy, 0);
        check_val("rstwin_ready", ready, 0);

        // Start held high throughout the generation: only the first is accepted.
        start_gen(16'h9A3C, 1'b1);
        wait_result("hold_start", 1'b0, old);

        // Restart from DONE: ready drops next cycle, old layout held until new DONE.
        old = init_mines;
        start_gen(16'h2468, 1'b0);
        check_val("restart_ready", ready, 0);
        check_val("restart_busy", busy, 1);
        wait_result("restart", 1'b1, old);

        safe_en  = 1'b1;
        safe_pos = 6'd27;
        for (int i = 0; i < 500; i++) begin
            start_gen(16'($urandom), 1'b0);
            wait_result("safe", 1'b0, old);
            check_val("safe_cell27", init_mines[27], 0);
        end

        // 63 of 64 cells filled with cell 0 protected.
        seed2  = 16'h0F0F;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (!ready2 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        exp63 = {1'b0, {63{1'b1}}};
        check_val("full_ready", ready2, 1);
        check_val("full_field", init2, exp63);
        check_val("full_count", count2, 63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
